// File: rtl/gpio_pkg.sv
// Shared definitions for the gpio_irq MMIO slave: slot FSM states, register map
// and parameter range checks.
`ifndef GPIO_PKG_SV
`define GPIO_PKG_SV

`define GPIO_PIN_W_OK(w) (((w) >= 1) && ((w) <= 32))
`define GPIO_SYNC_OK(s)  ((s) >= 2)

package gpio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } gpio_state_e;

  localparam logic [7:0] ADDR_OUT_DATA   = 8'h00;
  localparam logic [7:0] ADDR_OUT_SET    = 8'h04;
  localparam logic [7:0] ADDR_OUT_CLR    = 8'h08;
  localparam logic [7:0] ADDR_IN_DATA    = 8'h0C;
  localparam logic [7:0] ADDR_IRQ_EN     = 8'h10;
  localparam logic [7:0] ADDR_RISE_EN    = 8'h14;
  localparam logic [7:0] ADDR_FALL_EN    = 8'h18;
  localparam logic [7:0] ADDR_IRQ_STATUS = 8'h1C;
  localparam logic [7:0] ADDR_LAST       = ADDR_IRQ_STATUS;

endpackage

`endif

// File: rtl/gpio_debounce.sv
// One input pin: synchroniser chain, stability counter and debounced level, with
// single-cycle rise/fall pulses coincident with the edge that updates the level.
module gpio_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic arst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;
  logic                   w_flip;
  logic                   w_next;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    // Look one stage ahead so the pulse lines up with the level change.
    assign w_next  = r_sync[SYNC_STAGES-2];
    assign w_flip  = r_sync[SYNC_STAGES-2] ^ r_sync[SYNC_STAGES-1];
    assign o_level = w_synced;
  end else begin : g_debounce
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;

    assign w_next  = w_synced;
    assign w_flip  = (w_synced != r_level) && (r_cnt == LAST);
    assign o_level = r_level;

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else begin
        if ((w_synced == r_level) || w_flip) r_cnt <= '0;
        else                                 r_cnt <= r_cnt + 1'b1;
        if (w_flip) r_level <= w_synced;
      end
    end
  end

  assign o_rise = w_flip & w_next;
  assign o_fall = w_flip & ~w_next;

endmodule

// File: rtl/gpio_irq.sv
// GPIO slave on the MMIO slot bus: atomic set/clear outputs, debounced inputs
// with per-pin edge capture and a maskable level interrupt.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int NUM_INPUT       = 9,
  parameter int NUM_OUTPUT      = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  chip_select,
  input  logic                  read,
  input  logic                  write,
  input  logic                  transaction_completed,
  input  logic [7:0]            addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  wr_done,
  output logic                  rd_done,
  output logic                  idle,
  output logic                  slave_error,
  output logic                  decode_error,
  output logic                  irq,
  input  logic [NUM_INPUT-1:0]  in_ports,
  output logic [NUM_OUTPUT-1:0] out_ports
);

  if (!(`GPIO_PIN_W_OK(NUM_INPUT) && `GPIO_PIN_W_OK(NUM_OUTPUT) && `GPIO_SYNC_OK(SYNC_STAGES)))
  begin : g_param_err
    $error("gpio_irq: parameter out of range");
  end

  gpio_state_e r_state, w_state_nx;
  logic w_start, w_access, w_release;

  logic        r_req_wr, r_req_rd;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;

  logic [NUM_OUTPUT-1:0] r_out_data;
  logic [NUM_INPUT-1:0]  r_irq_en, r_rise_en, r_fall_en, r_status;
  logic [NUM_INPUT-1:0]  w_level, w_rise, w_fall, w_set, w_w1c;
  logic [NUM_OUTPUT-1:0] w_wd_o;
  logic [NUM_INPUT-1:0]  w_wd_i;

  logic        w_dec_err, w_slv_err, w_wr_ok, w_rd_ok;
  logic [31:0] w_rd_mux;
  logic        r_wr_done, r_rd_done, r_dec_err, r_slv_err;
  logic [31:0] r_rd_data;
  logic        w_unused;

  assign w_unused = ^r_wdata;

  // Input path
  for (genvar i = 0; i < NUM_INPUT; i++) begin : g_in
    gpio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .arst_n (arst_n),
      .i_pin  (in_ports[i]),
      .o_level(w_level[i]),
      .o_rise (w_rise[i]),
      .o_fall (w_fall[i])
    );
  end

  // Slot FSM
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (chip_select && (read || write)) w_state_nx = ACTIVE;
      ACTIVE:  w_state_nx = DONE;
      DONE:    if (transaction_completed) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    idle      = (r_state == IDLE);
    w_start   = (r_state == IDLE) && chip_select && (read || write);
    w_access  = (r_state == ACTIVE);
    w_release = (r_state == DONE) && transaction_completed;
  end

  // Request captured on acceptance so the master may drop it during ACTIVE.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_req_wr <= 1'b0;
      r_req_rd <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_start) begin
      r_req_wr <= write;
      r_req_rd <= read && !write;
      r_addr   <= addr;
      r_wdata  <= wr_data;
    end
  end

  // Decode
  always_comb begin
    w_dec_err = (r_addr[1:0] != 2'b00) || (r_addr > ADDR_LAST);
    w_slv_err = !w_dec_err &&
                ((r_req_wr && (r_addr == ADDR_IN_DATA)) ||
                 (r_req_rd && ((r_addr == ADDR_OUT_SET) || (r_addr == ADDR_OUT_CLR))));
    w_wr_ok   = w_access && r_req_wr && !w_dec_err && !w_slv_err;
    w_rd_ok   = w_access && r_req_rd && !w_dec_err && !w_slv_err;
    w_wd_o    = r_wdata[NUM_OUTPUT-1:0];
    w_wd_i    = r_wdata[NUM_INPUT-1:0];
  end

  always_comb begin
    w_rd_mux = '0;
    case (r_addr)
      ADDR_OUT_DATA:   w_rd_mux = 32'(r_out_data);
      ADDR_IN_DATA:    w_rd_mux = 32'(w_level);
      ADDR_IRQ_EN:     w_rd_mux = 32'(r_irq_en);
      ADDR_RISE_EN:    w_rd_mux = 32'(r_rise_en);
      ADDR_FALL_EN:    w_rd_mux = 32'(r_fall_en);
      ADDR_IRQ_STATUS: w_rd_mux = 32'(r_status);
      default:         w_rd_mux = '0;
    endcase
  end

  // Registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_out_data <= '0;
      r_irq_en   <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
    end else if (w_wr_ok) begin
      case (r_addr)
        ADDR_OUT_DATA: r_out_data <= w_wd_o;
        ADDR_OUT_SET:  r_out_data <= r_out_data | w_wd_o;
        ADDR_OUT_CLR:  r_out_data <= r_out_data & ~w_wd_o;
        ADDR_IRQ_EN:   r_irq_en   <= w_wd_i;
        ADDR_RISE_EN:  r_rise_en  <= w_wd_i;
        ADDR_FALL_EN:  r_fall_en  <= w_wd_i;
        default: ;
      endcase
    end
  end

  // A new edge on the same cycle as its W1C stays captured.
  assign w_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_w1c = (w_wr_ok && (r_addr == ADDR_IRQ_STATUS)) ? w_wd_i : '0;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_status <= '0;
    else         r_status <= (r_status & ~w_w1c) | w_set;
  end

  // Response
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
      r_dec_err <= 1'b0;
      r_slv_err <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_wr_done <= w_access && r_req_wr;
      r_rd_done <= w_access && r_req_rd;
      if (w_access) begin
        r_dec_err <= w_dec_err;
        r_slv_err <= w_slv_err;
      end else if (w_release) begin
        r_dec_err <= 1'b0;
        r_slv_err <= 1'b0;
      end
      if (w_access && r_req_rd) r_rd_data <= w_rd_ok ? w_rd_mux : '0;
    end
  end

  assign rd_data      = r_rd_data;
  assign wr_done      = r_wr_done;
  assign rd_done      = r_rd_done;
  assign slave_error  = r_slv_err;
  assign decode_error = r_dec_err;
  assign out_ports    = r_out_data;
  assign irq          = |(r_status & r_irq_en);

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq: directed scenarios plus randomized traffic
// against a cycle-level reference model of the register map and input filter.
module tb_gpio_irq;

  localparam int NI = 9;
  localparam int NO = 4;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int HL = S + D;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          chip_select = 1'b0, read = 1'b0, write = 1'b0, transaction_completed = 1'b0;
  logic [7:0]    addr = '0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data;
  logic          wr_done, rd_done, idle, slave_error, decode_error, irq;
  logic [NI-1:0] in_ports = '0;
  logic [NO-1:0] out_ports;

  int vec = 0;
  int errs = 0;

  gpio_irq #(.NUM_INPUT(NI), .NUM_OUTPUT(NO), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .arst_n(arst_n), .chip_select(chip_select), .read(read), .write(write),
    .transaction_completed(transaction_completed), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .wr_done(wr_done), .rd_done(rd_done), .idle(idle),
    .slave_error(slave_error), .decode_error(decode_error), .irq(irq),
    .in_ports(in_ports), .out_ports(out_ports)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          cyc = 0;
  logic        p_valid = 1'b0, p_wr = 1'b0, p_rd = 1'b0;
  int          p_at = 0;
  logic [7:0]  p_addr = '0;
  logic [31:0] p_data = '0;

  logic [NI-1:0] hist [HL];
  logic [NI-1:0] m_deb, m_status, m_irq_en, m_rise_en, m_fall_en;
  logic [NI-1:0] m_deb_nx, m_set, m_w1c;
  logic [NO-1:0] m_out;
  logic [31:0]   m_rd;

  // A pin's filtered level moves to v once the last D synchronised samples all equal v.
  always_comb begin
    m_deb_nx = ~m_deb;
    for (int b = 0; b < NI; b++)
      for (int j = S - 1; j <= S + D - 2; j++)
        if (hist[j][b] == m_deb[b]) m_deb_nx[b] = m_deb[b];
    m_set = (m_deb_nx & ~m_deb & m_rise_en) | (~m_deb_nx & m_deb & m_fall_en);
    m_w1c = (p_valid && (cyc + 1 == p_at) && p_wr && p_addr == 8'h1C) ? p_data[NI-1:0] : '0;
  end

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int j = 0; j < HL; j++) hist[j] <= '0;
      m_deb <= '0; m_status <= '0; m_irq_en <= '0; m_rise_en <= '0; m_fall_en <= '0;
      m_out <= '0; m_rd <= '0;
    end else begin
      cyc <= cyc + 1;
      hist[0] <= in_ports;
      for (int j = 1; j < HL; j++) hist[j] <= hist[j-1];
      m_deb    <= m_deb_nx;
      m_status <= (m_status & ~m_w1c) | m_set;
      if (p_valid && (cyc + 1 == p_at)) begin
        if (p_rd)
          case (p_addr)
            8'h00:   m_rd <= 32'(m_out);
            8'h0C:   m_rd <= 32'(m_deb);
            8'h10:   m_rd <= 32'(m_irq_en);
            8'h14:   m_rd <= 32'(m_rise_en);
            8'h18:   m_rd <= 32'(m_fall_en);
            8'h1C:   m_rd <= 32'(m_status);
            default: m_rd <= '0;
          endcase
        if (p_wr)
          case (p_addr)
            8'h00: m_out <= p_data[NO-1:0];
            8'h04: m_out <= m_out | p_data[NO-1:0];
            8'h08: m_out <= m_out & ~p_data[NO-1:0];
            8'h10: m_irq_en  <= p_data[NI-1:0];
            8'h14: m_rise_en <= p_data[NI-1:0];
            8'h18: m_fall_en <= p_data[NI-1:0];
            default: ;
          endcase
      end
    end
  end

  // ---------------- bus driver ----------------
  typedef struct {
    logic wrp, rdp, dec, slv, idle_act, idle0, held, idle_after, err_after;
    logic exp_dec, exp_slv;
    int   extra;
    logic [31:0] rd, exp_rd;
    logic [NO-1:0] out;
  } resp_t;

  // Call at a negedge. poke keeps a competing write to OUT_DATA asserted during DONE.
  task automatic bus(input logic wr, input logic rd, input logic [7:0] a, input logic [31:0] d,
                     input int hold, input bit poke, output resp_t r);
    r.exp_dec = (a[1:0] != 2'b00) || (a > 8'h1C);
    r.exp_slv = !r.exp_dec && ((wr && a == 8'h0C) || (!wr && rd && (a == 8'h04 || a == 8'h08)));
    p_at = cyc + 2; p_addr = a; p_data = d;
    p_wr = wr && !r.exp_dec && !r.exp_slv;
    p_rd = !wr && rd && !r.exp_dec && !r.exp_slv;
    p_valid = 1'b1;
    chip_select = 1'b1; read = rd; write = wr; addr = a; wr_data = d;
    @(negedge clk);
    r.idle_act = idle;
    @(negedge clk);
    r.wrp = wr_done; r.rdp = rd_done; r.dec = decode_error; r.slv = slave_error;
    r.rd = rd_data; r.idle0 = idle; r.out = out_ports;
    r.exp_rd = (r.exp_dec || r.exp_slv) ? 32'h0 : m_rd;
    chip_select = poke; read = 1'b0; write = poke; addr = 8'h00; wr_data = 32'hF;
    r.extra = 0; r.held = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      r.extra += int'(wr_done) + int'(rd_done);
      if (idle !== 1'b0 || decode_error !== r.dec || slave_error !== r.slv) r.held = 1'b0;
    end
    transaction_completed = 1'b1; chip_select = 1'b0; write = 1'b0;
    @(negedge clk);
    transaction_completed = 1'b0;
    r.idle_after = idle; r.err_after = decode_error | slave_error;
    r.extra += int'(wr_done) + int'(rd_done);
    p_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    vec++;
    if ({idle, wr_done, rd_done, slave_error, decode_error, irq, out_ports, rd_data} !== {1'b1, 5'b0, {NO{1'b0}}, 32'h0}) begin
      errs++; $display("FAIL reset_state got idle=%b wd=%b rd=%b se=%b de=%b irq=%b out=%h rdata=%h exp idle=1 rest=0",
                       idle, wr_done, rd_done, slave_error, decode_error, irq, out_ports, rd_data);
    end
    @(negedge clk); arst_n = 1'b1;
    repeat (2) @(negedge clk);
    vec++;
    if ({idle, out_ports, irq} !== {1'b1, {NO{1'b0}}, 1'b0}) begin
      errs++; $display("FAIL reset_release got idle=%b out=%h irq=%b", idle, out_ports, irq);
    end
  endtask

  task automatic test_out_set_clr();
    resp_t r;
    logic [7:0] a3 [3] = '{8'h00, 8'h04, 8'h08};
    logic [31:0] d3 [3] = '{32'h5, 32'h8, 32'h1};
    logic [NO-1:0] e3 [3] = '{4'h5, 4'hD, 4'hC};
    for (int i = 0; i < 3; i++) begin
      bus(1'b1, 1'b0, a3[i], d3[i], 0, 1'b0, r);
      vec++;
      if (r.out !== e3[i]) begin errs++; $display("FAIL out_seq%0d got=%h exp=%h", i, r.out, e3[i]); end
      vec++;
      if ({r.wrp, r.rdp, r.dec, r.slv, r.extra} !== {4'b1000, 32'd0}) begin
        errs++; $display("FAIL out_seq%0d_resp got wd=%b rd=%b de=%b se=%b extra=%0d exp wd=1 only", i, r.wrp, r.rdp, r.dec, r.slv, r.extra);
      end
    end
    for (int i = 0; i < 12; i++) begin
      bus(1'b1, 1'b0, a3[$urandom_range(0, 2)], $urandom, $urandom_range(0, 2), 1'b0, r);
      vec++;
      if (r.out !== m_out) begin errs++; $display("FAIL out_rand%0d got=%h exp=%h", i, r.out, m_out); end
    end
    bus(1'b0, 1'b1, 8'h00, 32'h0, 0, 1'b0, r);
    vec++;
    if (r.rd !== 32'(m_out)) begin errs++; $display("FAIL out_readback got=%h exp=%h", r.rd, m_out); end
  endtask

  task automatic test_debounce();
    resp_t r;
    in_ports = '0; repeat (12) @(negedge clk);
    // 6-cycle pulse on bit3: read early (before the filter releases) and late
    in_ports[3] = 1'b1;
    fork begin repeat (6) @(negedge clk); in_ports[3] = 1'b0; end join_none
    repeat (3) @(negedge clk);
    bus(1'b0, 1'b1, 8'h0C, 0, 0, 1'b0, r);
    vec++;
    if (r.rd !== 32'h0) begin errs++; $display("FAIL deb_early got=%h exp=0", r.rd); end
    repeat (14) @(negedge clk);
    in_ports[3] = 1'b1;
    fork begin repeat (6) @(negedge clk); in_ports[3] = 1'b0; end join_none
    repeat (5) @(negedge clk);
    bus(1'b0, 1'b1, 8'h0C, 0, 0, 1'b0, r);
    vec++;
    if (r.rd !== 32'h8) begin errs++; $display("FAIL deb_latency got=%h exp=8", r.rd); end
    repeat (14) @(negedge clk);
    // 3-cycle glitch on bit2
    in_ports[2] = 1'b1;
    fork begin repeat (3) @(negedge clk); in_ports[2] = 1'b0; end join_none
    repeat (4) @(negedge clk);
    bus(1'b0, 1'b1, 8'h0C, 0, 0, 1'b0, r);
    vec++;
    if (r.rd !== 32'h0) begin errs++; $display("FAIL deb_glitch got=%h exp=0", r.rd); end
    for (int i = 0; i < 30; i++) begin
      in_ports = NI'($urandom);
      repeat ($urandom_range(1, 7)) @(negedge clk);
      bus(1'b0, 1'b1, 8'h0C, 0, 0, 1'b0, r);
      vec++;
      if (r.rd !== r.exp_rd) begin errs++; $display("FAIL deb_rand%0d got=%h exp=%h", i, r.rd, r.exp_rd); end
    end
  endtask

  task automatic test_irq();
    resp_t r;
    in_ports = '0; repeat (12) @(negedge clk);
    bus(1'b1, 1'b0, 8'h1C, 32'h1FF, 0, 1'b0, r);
    bus(1'b1, 1'b0, 8'h14, 32'h1, 0, 1'b0, r);
    bus(1'b1, 1'b0, 8'h10, 32'h1, 0, 1'b0, r);
    in_ports[0] = 1'b1; repeat (10) @(negedge clk);
    bus(1'b0, 1'b1, 8'h1C, 0, 0, 1'b0, r);
    vec++;
    if ({r.rd, irq} !== {32'h1, 1'b1}) begin errs++; $display("FAIL irq_rise got status=%h irq=%b exp 1/1", r.rd, irq); end
    bus(1'b1, 1'b0, 8'h1C, 32'h1, 0, 1'b0, r);
    vec++;
    if (irq !== 1'b0) begin errs++; $display("FAIL irq_w1c got irq=%b exp=0", irq); end
    // fall edge landing on the same clock as a W1C of the same bit
    bus(1'b1, 1'b0, 8'h18, 32'h1, 0, 1'b0, r);
    in_ports[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus(1'b1, 1'b0, 8'h1C, 32'h1, 0, 1'b0, r);
    bus(1'b0, 1'b1, 8'h1C, 0, 0, 1'b0, r);
    vec++;
    if (r.rd !== 32'h1) begin errs++; $display("FAIL irq_set_wins got=%h exp=1", r.rd); end
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      case ($urandom_range(0, 4))
        0: begin in_ports = NI'($urandom); repeat ($urandom_range(1, 8)) @(negedge clk); end
        1: begin a = 8'h10 + 8'(4 * $urandom_range(0, 2)); bus(1'b1, 1'b0, a, $urandom, 0, 1'b0, r); end
        2: bus(1'b1, 1'b0, 8'h1C, $urandom, 0, 1'b0, r);
        default: begin
          bus(1'b0, 1'b1, 8'h1C, 0, 0, 1'b0, r);
          vec++;
          if (r.rd !== r.exp_rd) begin errs++; $display("FAIL irq_status_rand%0d got=%h exp=%h", i, r.rd, r.exp_rd); end
        end
      endcase
      vec++;
      if (irq !== |(m_status & m_irq_en)) begin errs++; $display("FAIL irq_rand%0d got=%b exp=%b", i, irq, |(m_status & m_irq_en)); end
    end
  endtask

  task automatic test_errors();
    resp_t r;
    logic [7:0] ra [4] = '{8'h04, 8'h08, 8'h40, 8'h02};
    logic       es [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bus(1'b1, 1'b0, 8'h00, 32'h6, 0, 1'b0, r);
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 1'b1, ra[i], 0, 0, 1'b0, r);
      vec++;
      if ({r.rdp, r.wrp, r.slv, r.dec, r.rd} !== {2'b10, es[i], ~es[i], 32'h0}) begin
        errs++; $display("FAIL err_read_%h got rdd=%b wrd=%b se=%b de=%b rdata=%h exp rdd=1 se=%b de=%b rdata=0",
                         ra[i], r.rdp, r.wrp, r.slv, r.dec, r.rd, es[i], ~es[i]);
      end
    end
    bus(1'b1, 1'b0, 8'h0C, 32'hFFFF, 0, 1'b0, r);
    vec++;
    if ({r.wrp, r.slv, r.dec} !== 3'b110) begin errs++; $display("FAIL err_write_in got wd=%b se=%b de=%b exp 1/1/0", r.wrp, r.slv, r.dec); end
    bus(1'b1, 1'b0, 8'h01, 32'hF, 0, 1'b0, r);
    vec++;
    if ({r.wrp, r.dec, r.out} !== {2'b11, 4'h6}) begin errs++; $display("FAIL err_misaligned_wr got wd=%b de=%b out=%h exp 1/1/6", r.wrp, r.dec, r.out); end
    bus(1'b1, 1'b1, 8'h00, 32'h9, 0, 1'b0, r);
    vec++;
    if ({r.wrp, r.rdp, r.out} !== {2'b10, 4'h9}) begin errs++; $display("FAIL err_write_wins got wd=%b rdd=%b out=%h exp 1/0/9", r.wrp, r.rdp, r.out); end
  endtask

  task automatic test_hold_done();
    resp_t r;
    bus(1'b1, 1'b0, 8'h00, 32'h3, 0, 1'b0, r);
    bus(1'b0, 1'b1, 8'h04, 0, 5, 1'b1, r);
    vec++;
    if ({r.idle0, r.held, r.extra, r.slv} !== {2'b01, 32'd0, 1'b1}) begin
      errs++; $display("FAIL hold_done got idle=%b held=%b extra=%0d se=%b exp 0/1/0/1", r.idle0, r.held, r.extra, r.slv);
    end
    vec++;
    if ({r.idle_after, r.err_after, out_ports} !== {2'b10, 4'h3}) begin
      errs++; $display("FAIL hold_release got idle=%b err=%b out=%h exp 1/0/3", r.idle_after, r.err_after, out_ports);
    end
  endtask

  task automatic test_reset_mid();
    resp_t r;
    int pulses;
    in_ports = '0; in_ports[1] = 1'b1;
    bus(1'b1, 1'b0, 8'h14, 32'h1FF, 0, 1'b0, r);
    repeat (10) @(negedge clk);
    chip_select = 1'b1; write = 1'b1; addr = 8'h00; wr_data = 32'hA;
    @(negedge clk);
    arst_n = 1'b0; #1;
    vec++;
    if ({idle, wr_done, rd_done, slave_error, decode_error, irq, out_ports, rd_data} !== {1'b1, 5'b0, {NO{1'b0}}, 32'h0}) begin
      errs++; $display("FAIL reset_mid got idle=%b wd=%b rd=%b out=%h rdata=%h exp idle=1 rest=0", idle, wr_done, rd_done, out_ports, rd_data);
    end
    chip_select = 1'b0; write = 1'b0;
    @(negedge clk); arst_n = 1'b1;
    pulses = 0;
    repeat (4) begin @(negedge clk); pulses += int'(wr_done) + int'(rd_done); end
    vec++;
    if ({pulses, out_ports, idle} !== {32'd0, {NO{1'b0}}, 1'b1}) begin
      errs++; $display("FAIL reset_mid_after got pulses=%0d out=%h idle=%b exp 0/0/1", pulses, out_ports, idle);
    end
    repeat (6) @(negedge clk);
    bus(1'b0, 1'b1, 8'h0C, 0, 0, 1'b0, r);
    vec++;
    if (r.rd !== 32'h2) begin errs++; $display("FAIL reset_pin_high got=%h exp=2", r.rd); end
    bus(1'b0, 1'b1, 8'h1C, 0, 0, 1'b0, r);
    vec++;
    if (r.rd !== 32'h0) begin errs++; $display("FAIL reset_no_capture got=%h exp=0", r.rd); end
  endtask

  initial begin
    test_reset();
    test_out_set_clr();
    test_debounce();
    test_irq();
    test_errors();
    test_hold_done();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
